// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the RV32 memory-access stage.
// Byte-enable, store-lane and alignment rules live here so every user agrees.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        MEM_ST_IDLE = 1'b0,
        MEM_ST_BUS  = 1'b1
    } mem_state_t;

    function automatic logic is_misaligned(mem_size_t size, logic [1:0] off);
        logic mis;
        case (size)
            MEM_SIZE_HALF: mis = off[0];
            MEM_SIZE_WORD: mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_byte_en(mem_size_t size, logic [1:0] off);
        logic [3:0] be;
        case (size)
            MEM_SIZE_BYTE: be = 4'b0001 << off;
            MEM_SIZE_HALF: be = 4'b0011 << off;
            MEM_SIZE_WORD: be = 4'b1111;
            default:       be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_store_data(mem_size_t size, logic [31:0] d);
        logic [31:0] sd;
        case (size)
            MEM_SIZE_BYTE: sd = {4{d[7:0]}};
            MEM_SIZE_HALF: sd = {2{d[15:0]}};
            default:       sd = d;
        endcase
        return sd;
    endfunction

endpackage

// File: rtl/stage_mem_if.sv
// Data-bus request/ready interface between the memory stage (master) and memory (slave).
interface stage_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    ready;

    modport master (
        output addr, wr_data, byte_en, read, write,
        input  rd_data, ready
    );

    modport slave (
        input  addr, wr_data, byte_en, read, write,
        output rd_data, ready
    );
endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed lane out of a bus read word and sign/zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [1:0]  off,
    input  logic [31:0] rd_data,
    output logic [31:0] value
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension of the returned word.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        value  = rd_data;
        case (off)
            2'd0:    byte_s = rd_data[7:0];
            2'd1:    byte_s = rd_data[15:8];
            2'd2:    byte_s = rd_data[23:16];
            default: byte_s = rd_data[31:24];
        endcase
        if (off[1]) begin
            half_s = rd_data[31:16];
        end else begin
            half_s = rd_data[15:0];
        end
        case (size)
            MEM_SIZE_BYTE: value = {{24{byte_s[7] & ~is_unsigned}}, byte_s};
            MEM_SIZE_HALF: value = {{16{half_s[15] & ~is_unsigned}}, half_s};
            default:       value = rd_data;
        endcase
    end
endmodule

// File: rtl/stage_mem.sv
// RV32 memory-access stage: issues loads/stores on the data bus, stalls EX while
// the bus is busy, and registers the write-back result into the MEM/WB boundary.
module stage_mem
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 5
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Valid,
    input  logic [DATA_WIDTH-1:0] i_Result,
    input  logic [DATA_WIDTH-1:0] i_StoreData,
    input  logic                  i_MemRead,
    input  logic                  i_MemWrite,
    input  logic [1:0]            i_MemSize,
    input  logic                  i_MemUnsigned,
    input  logic [REG_WIDTH-1:0]  i_RegWrAddr,
    input  logic                  i_RegWrEnable,
    output logic                  o_Stall,
    stage_mem_if.master           bus,
    output logic [DATA_WIDTH-1:0] o_RegWrData,
    output logic [REG_WIDTH-1:0]  o_RegWrAddr,
    output logic                  o_RegWrEnable,
    output logic                  o_Misaligned
);
    mem_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    mem_size_t               size_q, size_d;
    logic                    uns_q, uns_d;
    logic                    is_load_q, is_load_d;
    logic [REG_WIDTH-1:0]    rd_q, rd_d;
    logic                    wen_q, wen_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] be_q, be_d;
    logic [DATA_WIDTH-1:0]   rwdata_q, rwdata_d;
    logic [REG_WIDTH-1:0]    rwaddr_q, rwaddr_d;
    logic                    rwen_q, rwen_d;
    logic                    mis_q, mis_d;
    logic [DATA_WIDTH-1:0]   load_val_s;
    mem_size_t               size_in_s;

    assign size_in_s = mem_size_t'(i_MemSize);

    mem_load_align u_load_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .off         (addr_q[1:0]),
        .rd_data     (bus.rd_data),
        .value       (load_val_s)
    );

    // Next-state and write-back computation; inputs are only looked at in IDLE.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        is_load_d = is_load_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rwdata_d  = rwdata_q;
        rwaddr_d  = rwaddr_q;
        rwen_d    = 1'b0;
        mis_d     = 1'b0;
        case (state_q)
            MEM_ST_IDLE: begin
                if (i_Valid && (i_MemRead || i_MemWrite)) begin
                    if (is_misaligned(size_in_s, i_Result[1:0])) begin
                        mis_d = 1'b1;
                    end else begin
                        addr_d    = i_Result[ADDR_WIDTH-1:0];
                        size_d    = size_in_s;
                        uns_d     = i_MemUnsigned;
                        is_load_d = i_MemRead;
                        rd_d      = i_RegWrAddr;
                        wen_d     = i_RegWrEnable;
                        wdata_d   = lane_store_data(size_in_s, i_StoreData);
                        be_d      = lane_byte_en(size_in_s, i_Result[1:0]);
                        state_d   = MEM_ST_BUS;
                    end
                end else if (i_Valid) begin
                    rwdata_d = i_Result;
                    rwaddr_d = i_RegWrAddr;
                    rwen_d   = i_RegWrEnable;
                end else begin
                    rwen_d = 1'b0;
                end
            end
            MEM_ST_BUS: begin
                if (bus.ready) begin
                    state_d = MEM_ST_IDLE;
                    if (is_load_q) begin
                        rwdata_d = load_val_s;
                        rwaddr_d = rd_q;
                        rwen_d   = wen_q;
                    end else begin
                        rwen_d = 1'b0;
                    end
                end else begin
                    state_d = MEM_ST_BUS;
                end
            end
            default: state_d = MEM_ST_IDLE;
        endcase
    end

    // State, request and MEM/WB registers.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q   <= MEM_ST_IDLE;
            addr_q    <= '0;
            size_q    <= MEM_SIZE_BYTE;
            uns_q     <= 1'b0;
            is_load_q <= 1'b0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            rwdata_q  <= '0;
            rwaddr_q  <= '0;
            rwen_q    <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            is_load_q <= is_load_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rwdata_q  <= rwdata_d;
            rwaddr_q  <= rwaddr_d;
            rwen_q    <= rwen_d;
            mis_q     <= mis_d;
        end
    end

    // Strobes derive from the state flop so reset drops them without waiting for a clock.
    assign o_Stall       = (state_q == MEM_ST_BUS);
    assign bus.read      = o_Stall & is_load_q;
    assign bus.write     = o_Stall & ~is_load_q;
    assign bus.addr      = o_Stall ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.wr_data   = o_Stall ? wdata_q : '0;
    assign bus.byte_en   = o_Stall ? be_q : '0;
    assign o_RegWrData   = rwdata_q;
    assign o_RegWrAddr   = rwaddr_q;
    assign o_RegWrEnable = rwen_q;
    assign o_Misaligned  = mis_q;
endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: register writes are checked against a scoreboard queue.
module tb_stage_mem;
    import mem_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_Valid = 1'b0;
    logic [31:0] i_Result = 32'h0;
    logic [31:0] i_StoreData = 32'h0;
    logic        i_MemRead = 1'b0;
    logic        i_MemWrite = 1'b0;
    logic [1:0]  i_MemSize = 2'd0;
    logic        i_MemUnsigned = 1'b0;
    logic [4:0]  i_RegWrAddr = 5'd0;
    logic        i_RegWrEnable = 1'b0;
    logic        o_Stall;
    logic [31:0] o_RegWrData;
    logic [4:0]  o_RegWrAddr;
    logic        o_RegWrEnable;
    logic        o_Misaligned;

    int n_cmp = 0;
    int n_err = 0;
    wb_t sb[$];

    stage_mem_if bus_if ();

    stage_mem dut (
        .i_Clock       (clk),
        .i_Reset       (rst_n),
        .i_Valid       (i_Valid),
        .i_Result      (i_Result),
        .i_StoreData   (i_StoreData),
        .i_MemRead     (i_MemRead),
        .i_MemWrite    (i_MemWrite),
        .i_MemSize     (i_MemSize),
        .i_MemUnsigned (i_MemUnsigned),
        .i_RegWrAddr   (i_RegWrAddr),
        .i_RegWrEnable (i_RegWrEnable),
        .o_Stall       (o_Stall),
        .bus           (bus_if),
        .o_RegWrData   (o_RegWrData),
        .o_RegWrAddr   (o_RegWrAddr),
        .o_RegWrEnable (o_RegWrEnable),
        .o_Misaligned  (o_Misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [31:0] sd,
                         input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [4:0] ra, input logic we);
        i_Valid = v; i_Result = res; i_StoreData = sd; i_MemRead = rd; i_MemWrite = wr;
        i_MemSize = sz; i_MemUnsigned = uns; i_RegWrAddr = ra; i_RegWrEnable = we;
    endtask

    // Scoreboard monitor: every write-back must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && o_RegWrEnable) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", {27'd0, o_RegWrAddr}, 32'hFFFF_FFFF);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("sb_data", o_RegWrData, e.data);
                chk("sb_addr", {27'd0, o_RegWrAddr}, {27'd0, e.addr});
                chk("sb_no_mis", {31'd0, o_Misaligned}, 32'd0);
            end
        end
    end

    initial begin
        bus_if.rd_data = 32'h0;
        bus_if.ready   = 1'b0;
        tick();
        tick();
        chk("rst_stall", {31'd0, o_Stall}, 32'd0);
        chk("rst_read", {31'd0, bus_if.read}, 32'd0);
        chk("rst_write", {31'd0, bus_if.write}, 32'd0);
        chk("rst_be", {28'd0, bus_if.byte_en}, 32'd0);
        chk("rst_rwen", {31'd0, o_RegWrEnable}, 32'd0);
        chk("rst_mis", {31'd0, o_Misaligned}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: ALU op
        drive(1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd5, 1'b1);
        sb.push_back('{data: 32'hDEAD_BEEF, addr: 5'd5});
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0);
        chk("alu_data", o_RegWrData, 32'hDEAD_BEEF);
        chk("alu_en", {31'd0, o_RegWrEnable}, 32'd1);
        chk("alu_stall", {31'd0, o_Stall}, 32'd0);
        tick();
        chk("bubble_en", {31'd0, o_RegWrEnable}, 32'd0);

        // 2: LB 0x1003 with two wait cycles, signed
        drive(1'b1, 32'h0000_1003, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd7, 1'b1);
        sb.push_back('{data: 32'hFFFF_FF80, addr: 5'd7});
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("lb_be", {28'd0, bus_if.byte_en}, 32'h8);
            chk("lb_addr", bus_if.addr, 32'h0000_1000);
            chk("lb_read", {31'd0, bus_if.read}, 32'd1);
            chk("lb_stall", {31'd0, o_Stall}, 32'd1);
            chk("lb_wait_en", {31'd0, o_RegWrEnable}, 32'd0);
            if (c == 2) begin
                bus_if.ready = 1'b1;
                bus_if.rd_data = 32'h80FF_FF00;
            end
            tick();
        end
        bus_if.ready = 1'b0;
        chk("lb_data", o_RegWrData, 32'hFFFF_FF80);
        chk("lb_en", {31'd0, o_RegWrEnable}, 32'd1);
        chk("lb_done_read", {31'd0, bus_if.read}, 32'd0);
        chk("lb_done_stall", {31'd0, o_Stall}, 32'd0);

        // 2b: LBU same address, zero-wait
        drive(1'b1, 32'h0000_1003, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 5'd8, 1'b1);
        sb.push_back('{data: 32'h0000_0080, addr: 5'd8});
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0);
        bus_if.ready = 1'b1;
        bus_if.rd_data = 32'h80FF_FF00;
        chk("lbu_stall", {31'd0, o_Stall}, 32'd1);
        tick();
        bus_if.ready = 1'b0;
        chk("lbu_data", o_RegWrData, 32'h0000_0080);
        chk("lbu_en", {31'd0, o_RegWrEnable}, 32'd1);

        // 3: SH 0x2002, ready immediately
        drive(1'b1, 32'h0000_2002, 32'h1234_ABCD, 1'b0, 1'b1, 2'd1, 1'b0, 5'd3, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0);
        bus_if.ready = 1'b1;
        chk("sh_write", {31'd0, bus_if.write}, 32'd1);
        chk("sh_read", {31'd0, bus_if.read}, 32'd0);
        chk("sh_be", {28'd0, bus_if.byte_en}, 32'hC);
        chk("sh_wdata", bus_if.wr_data, 32'hABCD_ABCD);
        chk("sh_addr", bus_if.addr, 32'h0000_2000);
        chk("sh_stall", {31'd0, o_Stall}, 32'd1);
        tick();
        bus_if.ready = 1'b0;
        chk("sh_done_write", {31'd0, bus_if.write}, 32'd0);
        chk("sh_done_stall", {31'd0, o_Stall}, 32'd0);
        chk("sh_en", {31'd0, o_RegWrEnable}, 32'd0);

        // 4: misaligned LW 0x3001
        drive(1'b1, 32'h0000_3001, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd4, 1'b1);
        #1;
        chk("mis_no_strobe", {31'd0, bus_if.read}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0);
        chk("mis_pulse", {31'd0, o_Misaligned}, 32'd1);
        chk("mis_en", {31'd0, o_RegWrEnable}, 32'd0);
        chk("mis_stall", {31'd0, o_Stall}, 32'd0);
        chk("mis_read", {31'd0, bus_if.read}, 32'd0);
        tick();
        chk("mis_cleared", {31'd0, o_Misaligned}, 32'd0);

        // 5: reset during a bus wait
        drive(1'b1, 32'h0000_4000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd9, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0);
        chk("rstbus_read_before", {31'd0, bus_if.read}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstbus_read", {31'd0, bus_if.read}, 32'd0);
        chk("rstbus_stall", {31'd0, o_Stall}, 32'd0);
        chk("rstbus_en", {31'd0, o_RegWrEnable}, 32'd0);
        rst_n = 1'b1;
        tick();
        bus_if.ready = 1'b1;
        bus_if.rd_data = 32'h5555_AAAA;
        tick();
        bus_if.ready = 1'b0;
        chk("rstbus_no_write", {31'd0, o_RegWrEnable}, 32'd0);
        chk("rstbus_idle", {31'd0, o_Stall}, 32'd0);

        // 6: LW 0x0 then ALU op held under stall
        drive(1'b1, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd10, 1'b1);
        sb.push_back('{data: 32'h1122_3344, addr: 5'd10});
        tick();
        drive(1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd11, 1'b1);
        sb.push_back('{data: 32'hCAFE_F00D, addr: 5'd11});
        bus_if.ready = 1'b1;
        bus_if.rd_data = 32'h1122_3344;
        chk("b2b_stall", {31'd0, o_Stall}, 32'd1);
        tick();
        bus_if.ready = 1'b0;
        chk("b2b_ld_data", o_RegWrData, 32'h1122_3344);
        chk("b2b_ld_en", {31'd0, o_RegWrEnable}, 32'd1);
        chk("b2b_unstall", {31'd0, o_Stall}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0);
        chk("b2b_alu_data", o_RegWrData, 32'hCAFE_F00D);
        chk("b2b_alu_addr", {27'd0, o_RegWrAddr}, 32'd11);
        chk("b2b_alu_en", {31'd0, o_RegWrEnable}, 32'd1);
        tick();
        chk("b2b_no_dup", {31'd0, o_RegWrEnable}, 32'd0);
        tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
